mv_col_sched: RTL and testbench

- Column scheduler for the 16 x 256-bit matrix column selector in the PE.
- Drives the selector's en/ready pins to present NUM_COLS (or fewer) columns, one at a time, to the downstream dot/MAC PE over a valid/ready handshake.
- Generates clean_dot/last framing and realigns the selector's column counter to 0 after every job.
- Sits between the top-level job controller (start/done) and the selector+PE pair.

---
 rtl/mv_pkg.sv | 20 ++
 rtl/mv_col_sched.sv | 151 +++++++++++++++
 tb/tb_mv_col_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mv_pkg.sv
// Shared constants for the matrix column scheduler: default geometry,
// FSM state encoding and PE mode encodings.
package mv_pkg;

  localparam int DEF_NUM_COLS = 16;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_SEL_LAT  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic MODE_MATVEC = 1'b0;
  localparam logic MODE_DOT    = 1'b1;

endpackage

// File: rtl/mv_col_sched.sv
// Column scheduler: steps the 16-column matrix selector through one job,
// presents each column to the PE over valid/ready, frames it with
// clean_dot/last, then spins the selector back to column 0.
// Optional build macro MV_COL_SCHED_PERF_EN adds a 16-bit stall counter.
module mv_col_sched
  import mv_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int SEL_LAT  = DEF_SEL_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   n_cols,
  input  logic             mode,
  output logic             busy,
  output logic             sel_en,
  output logic             sel_ready,
  output logic [IDX_W-1:0] col_idx,
  output logic             pe_valid,
  input  logic             pe_ready,
  output logic             clean_dot,
  output logic             last,
  output logic             done,
  output logic             err
`ifdef MV_COL_SCHED_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // Wait counter must hold SEL_LAT (reload after a handshake).
  localparam int WAIT_W = (SEL_LAT < 2) ? 1 : $clog2(SEL_LAT + 1);
  localparam logic [WAIT_W-1:0] LAT_FULL  = WAIT_W'(SEL_LAT);
  localparam logic [WAIT_W-1:0] LAT_FIRST = WAIT_W'(SEL_LAT - 1);
  localparam logic [IDX_W:0]    N_MAX     = (IDX_W + 1)'(NUM_COLS);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [IDX_W:0]    n_lat;
  logic              mode_lat;

  logic              n_legal;
  logic [IDX_W:0]    last_idx;
  logic              beat_last;
  logic              beat_first;

  assign n_legal    = (n_cols != '0) && (n_cols <= N_MAX);
  assign last_idx   = n_lat - (IDX_W + 1)'(1);
  // The beat index equals col_idx because every job starts at column 0.
  assign beat_last  = ({1'b0, col_idx} == last_idx);
  assign beat_first = (col_idx == '0);
  assign sel_en     = busy;

  // Job FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      n_lat     <= '0;
      mode_lat  <= MODE_MATVEC;
      col_idx   <= '0;
      busy      <= 1'b0;
      sel_ready <= 1'b0;
      pe_valid  <= 1'b0;
      clean_dot <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sel_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            n_lat    <= n_cols;
            mode_lat <= mode;
            if (!n_legal) begin
              // Rejected job: finish immediately, selector untouched.
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= LOAD;
              wait_cnt <= LAT_FIRST;
            end
          end
        end
        LOAD: begin
          if (wait_cnt == '0) begin
            state     <= ISSUE;
            pe_valid  <= 1'b1;
            clean_dot <= (mode_lat == MODE_DOT) || beat_first;
            last      <= beat_last;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ISSUE: begin
          // Beat held stable until the PE takes it.
          if (pe_ready) begin
            pe_valid  <= 1'b0;
            clean_dot <= 1'b0;
            last      <= 1'b0;
            sel_ready <= 1'b1;
            col_idx   <= col_idx + 1'b1;
            if (last) begin
              state <= FLUSH;
            end else begin
              // Extra cycle: selector samples the advance pulse first.
              state    <= LOAD;
              wait_cnt <= LAT_FULL;
            end
          end
        end
        FLUSH: begin
          // Keep advancing the selector until both counters sit at 0.
          if (col_idx == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            sel_ready <= 1'b1;
            col_idx   <= col_idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MV_COL_SCHED_PERF_EN
  // Saturating count of cycles a valid beat waits on the PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == ISSUE && !pe_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mv_col_sched.sv
// Self-checking bench for mv_col_sched. Each job's expected waveform is
// laid out as a per-cycle table from the timing rules (latency, stalls,
// flush length), then compared against the DUT cycle by cycle.
module tb_mv_col_sched;

  localparam int NUM_COLS = 16;
  localparam int SEL_LAT  = 2;
  localparam int MAXE     = 300;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] n_cols;
  logic       mode;
  logic       busy, sel_en, sel_ready, pe_valid, pe_ready;
  logic       clean_dot, last, done, err;
  logic [3:0] col_idx;
`ifdef MV_COL_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int nvec = 0;
  int nmis = 0;

  // Expected-waveform tables, index = window after edge e of the job.
  bit rdy    [MAXE];
  bit e_vld  [MAXE];
  bit e_cd   [MAXE];
  bit e_last [MAXE];
  bit e_sr   [MAXE];
  bit c_set  [MAXE];
  int c_val  [MAXE];

  logic [11:0] obs;
  assign obs = {busy, sel_en, sel_ready, col_idx, pe_valid, clean_dot, last, done, err};

  mv_col_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_cols    (n_cols),
    .mode      (mode),
    .busy      (busy),
    .sel_en    (sel_en),
    .sel_ready (sel_ready),
    .col_idx   (col_idx),
    .pe_valid  (pe_valid),
    .pe_ready  (pe_ready),
    .clean_dot (clean_dot),
    .last      (last),
    .done      (done),
    .err       (err)
`ifdef MV_COL_SCHED_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // stl: 0 = PE always ready, 1 = random 0..3 stall cycles per beat,
  //      2 = four stall cycles on beat 1 only.
  // jnk: toggle start/n_cols/mode randomly while the job is busy.
  task automatic run_job(input int n, input bit md, input int stl, input bit jnk);
    int x, ek, dn, p, s, stall_exp, cur;
    bit legal;
    logic [11:0] want;
    for (int e = 0; e < MAXE; e++) begin
      rdy[e] = 1'($urandom_range(0, 1));
      e_vld[e] = 0; e_cd[e] = 0; e_last[e] = 0; e_sr[e] = 0;
      c_set[e] = 0; c_val[e] = 0;
    end
    legal = (n >= 1) && (n <= NUM_COLS);
    stall_exp = 0;
    dn = 0;
    if (legal) begin
      x = SEL_LAT;  // first beat visible after edge SEL_LAT
      for (int b = 0; b < n; b++) begin
        s = (stl == 1) ? int'($urandom_range(0, 3)) : ((stl == 2 && b == 1) ? 4 : 0);
        ek = x + 1 + s;
        for (int e = x; e < ek; e++) begin
          e_vld[e]  = 1;
          e_cd[e]   = md || (b == 0);
          e_last[e] = (b == n - 1);
        end
        for (int e = x + 1; e < ek; e++) rdy[e] = 0;
        rdy[ek] = 1;
        stall_exp += s;
        if (b < n - 1) begin
          e_sr[ek] = 1; c_set[ek] = 1; c_val[ek] = b + 1;
          x = ek + 1 + SEL_LAT;
        end else begin
          p = NUM_COLS - n + 1;
          for (int j = 0; j < p; j++) begin
            e_sr[ek + j] = 1; c_set[ek + j] = 1; c_val[ek + j] = (n + j) % NUM_COLS;
          end
          dn = ek + p;
        end
      end
    end
    start  = 1'b1;
    n_cols = 5'(n);
    mode   = md;
    cur    = 0;
    for (int e = 0; e <= dn + 1; e++) begin
      @(posedge clk);
      #1;
      start = jnk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (e == dn + 1) start = 1'b0;
      if (jnk) begin
        n_cols = 5'($urandom);
        mode   = 1'($urandom);
      end
      pe_ready = rdy[e + 1];
      @(negedge clk);
      if (c_set[e]) cur = c_val[e];
      want = {(e <= dn), (e <= dn), e_sr[e], 4'(cur), e_vld[e], e_cd[e], e_last[e],
              (e == dn), (e == dn) && !legal};
      chk($sformatf("cyc%0d_n%0d_m%0d", e, n, md), 32'(obs), 32'(want));
    end
`ifdef MV_COL_SCHED_PERF_EN
    chk($sformatf("stall_n%0d", n), 32'(stall_cnt), 32'(stall_exp));
`endif
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; n_cols = '0; mode = 1'b0; pe_ready = 1'b0;
    #3;
    chk("rst_async", 32'(obs), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold", 32'(obs), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle", 32'(obs), 32'd0);

    run_job(16, 1'b0, 0, 1'b0);   // full matvec
    run_job(5,  1'b1, 0, 1'b0);   // partial dot
    run_job(5,  1'b1, 1, 1'b0);   // back-to-back, starts the cycle after done
    run_job(3,  1'b0, 2, 1'b0);   // backpressure on beat 1
    run_job(0,  1'b0, 0, 1'b0);   // illegal low
    run_job(17, 1'b1, 0, 1'b0);   // illegal high
    run_job(4,  1'b0, 1, 1'b1);   // start hammered while busy
    run_job(1,  1'b1, 1, 1'b1);
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 4) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31));
      else n = int'($urandom_range(1, 16));
      run_job(n, 1'($urandom), 1, 1'($urandom));
    end

    // Async reset in the middle of a full job, between clock edges.
    start = 1'b1; n_cols = 5'd16; mode = 1'b0; pe_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_mid", 32'(obs), 32'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", c), 32'(obs), 32'd0);
    end
    run_job(6, 1'b0, 1, 1'b0);
    run_job(16, 1'b1, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
